// File: rtl/dmem_responder.sv
// dmem_responder: single-port data memory behind a valid/ready load/store
// interface. Each request passes through IDLE -> WAIT -> RESP. The WAIT
// state is skipped when WAIT_CYCLES is 0. Stores are committed on the edge
// that enters RESP. Load data is registered on that same edge.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rstd,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] BYTES     = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      r_state, w_next;
    logic [3:0]  r_cnt;
    logic        r_we, r_uns, r_err;
    logic [31:0] r_addr, r_wdata, r_rdata;
    logic [1:0]  r_size;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic        w_in_idle, w_accept, w_enter_resp, w_err, w_mem_we;
    logic        w_cur_we, w_cur_uns;
    logic [31:0] w_cur_addr, w_cur_wdata, w_word, w_wlane, w_ld;
    logic [1:0]  w_cur_size;
    logic [3:0]  w_be;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [AW-1:0] w_idx;

    assign w_in_idle  = (r_state == IDLE);
    assign w_accept   = w_in_idle && req_valid;
    assign req_ready  = w_in_idle;
    assign resp_valid = (r_state == RESP);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

    // In IDLE the live inputs describe the access. This matters for the
    // zero-wait build, where RESP is entered on the accept edge itself.
    // Outside IDLE only the captured copy is used.
    assign w_cur_we    = w_in_idle ? req_we       : r_we;
    assign w_cur_addr  = w_in_idle ? req_addr     : r_addr;
    assign w_cur_size  = w_in_idle ? req_size     : r_size;
    assign w_cur_uns   = w_in_idle ? req_unsigned : r_uns;
    assign w_cur_wdata = w_in_idle ? req_wdata    : r_wdata;

    assign w_idx  = w_cur_addr[AW+1:2];
    assign w_word = r_mem[w_idx];

    // Next-state logic; also flags the edge on which RESP is entered.
    always_comb begin
        w_next       = r_state;
        w_enter_resp = 1'b0;
        case (r_state)
            IDLE: if (req_valid) begin
                if (WAIT_CYCLES == 0) begin
                    w_next       = RESP;
                    w_enter_resp = 1'b1;
                end else begin
                    w_next = WAIT;
                end
            end
            WAIT: if (r_cnt == 4'd1) begin
                w_next       = RESP;
                w_enter_resp = 1'b1;
            end
            RESP: if (resp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Error decode: illegal size, misalignment, or address beyond storage.
    always_comb begin
        w_err = 1'b0;
        case (w_cur_size)
            2'b11:   w_err = 1'b1;
            2'b01:   w_err = w_cur_addr[0];
            2'b10:   w_err = |w_cur_addr[1:0];
            default: w_err = 1'b0;
        endcase
        if ({1'b0, w_cur_addr} >= BYTES) w_err = 1'b1;
    end

    // Lane enables and replicated store data. Load lane select and extension.
    always_comb begin
        w_be    = 4'b1111;
        w_wlane = w_cur_wdata;
        case (w_cur_size)
            2'b00: begin
                w_be    = 4'b0001 << w_cur_addr[1:0];
                w_wlane = {4{w_cur_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = w_cur_addr[1] ? 4'b1100 : 4'b0011;
                w_wlane = {2{w_cur_wdata[15:0]}};
            end
            default: ;
        endcase
        w_byte = w_word[{w_cur_addr[1:0], 3'b000} +: 8];
        w_half = w_word[{w_cur_addr[1], 4'b0000} +: 16];
        case (w_cur_size)
            2'b00:   w_ld = w_cur_uns ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
            2'b01:   w_ld = w_cur_uns ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
            default: w_ld = w_word;
        endcase
    end

    // Reset gates the write so an access cut short by reset never lands.
    assign w_mem_we = w_enter_resp && w_cur_we && !w_err && !rstd;

    // Storage: no reset, byte-lane writes.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wlane[8*i +: 8];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rstd) begin
        if (rstd) r_state <= IDLE;
        else      r_state <= w_next;
    end

    // Request capture, wait counter and registered response.
    always_ff @(posedge clk or posedge rstd) begin
        if (rstd) begin
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_addr  <= 32'd0;
            r_size  <= 2'd0;
            r_uns   <= 1'b0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we    <= req_we;
                r_addr  <= req_addr;
                r_size  <= req_size;
                r_uns   <= req_unsigned;
                r_wdata <= req_wdata;
                r_cnt   <= WAIT_INIT;
            end else if (r_state == WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_enter_resp) begin
                r_err   <= w_err;
                r_rdata <= (w_cur_we || w_err) ? 32'd0 : w_ld;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder. The main instance uses
// WAIT_CYCLES=2 and DEPTH_WORDS=256. A second instance uses WAIT_CYCLES=0
// and covers the zero-latency build. Expected data comes from a byte-array
// memory model.
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstd;
    logic        req_valid, req_ready, req_we, req_unsigned, resp_valid, resp_ready, resp_err;
    logic [31:0] req_addr, req_wdata, resp_rdata;
    logic [1:0]  req_size;

    logic        req_valid0, req_ready0, req_we0, req_unsigned0, resp_valid0, resp_ready0, resp_err0;
    logic [31:0] req_addr0, req_wdata0, resp_rdata0;
    logic [1:0]  req_size0;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] mem_b [0:1023];

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rstd(rstd), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    dmem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rstd(rstd), .req_valid(req_valid0), .req_ready(req_ready0),
        .req_we(req_we0), .req_addr(req_addr0), .req_size(req_size0),
        .req_unsigned(req_unsigned0), .req_wdata(req_wdata0), .resp_valid(resp_valid0),
        .resp_ready(resp_ready0), .resp_rdata(resp_rdata0), .resp_err(resp_err0)
    );

    // Reference: memory is a flat byte array of 1024 bytes, little endian.
    task automatic model(input logic we, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] wd,
                         output logic [31:0] rd, output logic err);
        int n;
        logic [63:0] v;
        n   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        err = (size == 2'd3) || ((addr % n) != 0) || (addr >= 32'd1024);
        rd  = 32'd0;
        if (!err) begin
            if (we) begin
                for (int i = 0; i < n; i++) mem_b[addr + i] = wd[8*i +: 8];
            end else begin
                v = 64'd0;
                for (int i = 0; i < n; i++) v = v | (64'(mem_b[addr + i]) << (8*i));
                if (!uns && v[8*n-1]) v = v | (~64'd0 << (8*n));
                rd = v[31:0];
            end
        end
    endtask

    // One transaction on the main instance. Request inputs are scrambled
    // after the accept edge, and lat counts cycles from accept to response.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                          input logic uns, input logic [31:0] wd,
                          output logic [31:0] rd, output logic err, output int lat);
        int cnt;
        @(negedge clk);
        req_we = we; req_addr = addr; req_size = size; req_unsigned = uns; req_wdata = wd;
        req_valid = 1'b1;
        cnt = 0;
        while (!req_ready && cnt < 20) begin @(negedge clk); cnt++; end
        if (!req_ready) begin
            n_total++;
            $display("FAIL accept_timeout req_ready=%b want=1", req_ready);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_we = 1'($urandom); req_addr = $urandom; req_size = 2'($urandom);
        req_unsigned = 1'($urandom); req_wdata = $urandom;
        lat = 1;
        while (!resp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        rd  = resp_rdata;
        err = resp_err;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rstd = 1'b1;
        #2;
        n_total++; if (req_ready !== 1'b1) $display("FAIL rst_req_ready got=%b want=1", req_ready); else n_pass++;
        n_total++; if (resp_valid !== 1'b0) $display("FAIL rst_resp_valid got=%b want=0", resp_valid); else n_pass++;
        n_total++; if (resp_rdata !== 32'd0) $display("FAIL rst_rdata got=%h want=0", resp_rdata); else n_pass++;
        n_total++; if (resp_err !== 1'b0) $display("FAIL rst_err got=%b want=0", resp_err); else n_pass++;
        n_total++; if (req_ready0 !== 1'b1) $display("FAIL rst0_req_ready got=%b want=1", req_ready0); else n_pass++;
        n_total++; if (resp_valid0 !== 1'b0) $display("FAIL rst0_resp_valid got=%b want=0", resp_valid0); else n_pass++;
        @(negedge clk);
        rstd = 1'b0;
    endtask

    // Give every word a known value so later loads have defined expectations.
    task automatic test_fill();
        logic [31:0] rd, erd, wd;
        logic err, eerr;
        int lat;
        for (int w = 0; w < 256; w++) begin
            wd = $urandom;
            model(1'b1, 32'(w*4), 2'b10, 1'b0, wd, erd, eerr);
            do_req(1'b1, 32'(w*4), 2'b10, 1'b0, wd, rd, err, lat);
            n_total++; if (err !== 1'b0 || rd !== 32'd0) $display("FAIL fill_store w=%0d err=%b rdata=%h want err=0 rdata=0", w, err, rd); else n_pass++;
        end
    endtask

    task automatic test_directed();
        logic [31:0] rd, erd;
        logic err, eerr;
        int lat;
        model(1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, erd, eerr);
        do_req(1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, rd, err, lat);
        n_total++; if (lat !== 3) $display("FAIL store_latency got=%0d want=3", lat); else n_pass++;
        do_req(1'b0, 32'h10, 2'b10, 1'b1, 32'h0, rd, err, lat);
        n_total++; if (rd !== 32'hDEADBEEF || err !== 1'b0) $display("FAIL load_word got=%h/%b want=deadbeef/0", rd, err); else n_pass++;
        n_total++; if (lat !== 3) $display("FAIL load_latency got=%0d want=3", lat); else n_pass++;
        model(1'b1, 32'h11, 2'b00, 1'b0, 32'h80, erd, eerr);
        do_req(1'b1, 32'h11, 2'b00, 1'b0, 32'hFFFFFF80, rd, err, lat);
        do_req(1'b0, 32'h11, 2'b00, 1'b0, 32'h0, rd, err, lat);
        n_total++; if (rd !== 32'hFFFFFF80) $display("FAIL load_byte_signed got=%h want=ffffff80", rd); else n_pass++;
        do_req(1'b0, 32'h11, 2'b00, 1'b1, 32'h0, rd, err, lat);
        n_total++; if (rd !== 32'h00000080) $display("FAIL load_byte_unsigned got=%h want=00000080", rd); else n_pass++;
        do_req(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, rd, err, lat);
        n_total++; if (rd !== 32'hDEAD80EF) $display("FAIL load_word_merged got=%h want=dead80ef", rd); else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] rd, erd, addr, wd, mask;
        logic [1:0] size;
        logic err, eerr, we, uns;
        int lat, pick;
        for (int k = 0; k < 300; k++) begin
            we   = 1'($urandom_range(0, 1));
            uns  = 1'($urandom_range(0, 1));
            size = 2'($urandom_range(0, 3));
            wd   = $urandom;
            pick = $urandom_range(0, 9);
            if (pick == 0)      addr = 32'd1024 + 32'($urandom_range(0, 64));
            else if (pick == 1) addr = $urandom;
            else                addr = 32'($urandom_range(0, 1023));
            mask = (size == 2'd1) ? 32'd1 : (size == 2'd2) ? 32'd3 : 32'd0;
            if ($urandom_range(0, 3) != 0) addr = addr & ~mask;
            model(we, addr, size, uns, wd, erd, eerr);
            do_req(we, addr, size, uns, wd, rd, err, lat);
            n_total++; if (err !== eerr) $display("FAIL rnd_err k=%0d addr=%h size=%0d got=%b want=%b", k, addr, size, err, eerr); else n_pass++;
            n_total++; if (rd !== erd) $display("FAIL rnd_rdata k=%0d addr=%h size=%0d got=%h want=%h", k, addr, size, rd, erd); else n_pass++;
            n_total++; if (lat !== 3) $display("FAIL rnd_latency k=%0d got=%0d want=3", k, lat); else n_pass++;
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd, erd;
        logic err, eerr;
        int lat, bad;
        do_req(1'b0, 32'h13, 2'b01, 1'b0, 32'h0, rd, err, lat);
        n_total++; if (err !== 1'b1 || rd !== 32'd0) $display("FAIL misaligned_half got=%h/%b want=0/1", rd, err); else n_pass++;
        do_req(1'b1, 32'h400, 2'b10, 1'b0, 32'hCAFEF00D, rd, err, lat);
        n_total++; if (err !== 1'b1) $display("FAIL oor_store_err got=%b want=1", err); else n_pass++;
        bad = 0;
        for (int w = 0; w < 256; w++) begin
            model(1'b0, 32'(w*4), 2'b10, 1'b1, 32'h0, erd, eerr);
            do_req(1'b0, 32'(w*4), 2'b10, 1'b1, 32'h0, rd, err, lat);
            if (rd !== erd) begin
                bad++;
                if (bad < 4) $display("FAIL mem_word w=%0d got=%h want=%h", w, rd, erd);
            end
        end
        n_total++; if (bad !== 0) $display("FAIL mem_unchanged bad_words=%0d want=0", bad); else n_pass++;
    endtask

    // Response held for five cycles while the initiator keeps pushing requests.
    task automatic test_hold();
        logic [31:0] erd;
        logic eerr;
        int cnt;
        model(1'b0, 32'h10, 2'b10, 1'b1, 32'h0, erd, eerr);
        @(negedge clk);
        req_we = 1'b0; req_addr = 32'h10; req_size = 2'b10; req_unsigned = 1'b1; req_valid = 1'b1;
        @(posedge clk); #1;
        cnt = 0;
        while (!resp_valid && cnt < 20) begin req_addr = $urandom; req_we = 1'($urandom); @(posedge clk); #1; cnt++; end
        for (int c = 0; c < 5; c++) begin
            n_total++; if (resp_valid !== 1'b1 || req_ready !== 1'b0) $display("FAIL hold_handshake c=%0d valid=%b ready=%b want 1/0", c, resp_valid, req_ready); else n_pass++;
            n_total++; if (resp_rdata !== erd || resp_err !== eerr) $display("FAIL hold_data c=%0d got=%h/%b want=%h/%b", c, resp_rdata, resp_err, erd, eerr); else n_pass++;
            req_addr = $urandom; req_we = 1'($urandom); req_wdata = $urandom;
            @(posedge clk); #1;
        end
        resp_ready = 1'b1; req_valid = 1'b0;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        n_total++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) $display("FAIL hold_release valid=%b ready=%b want 0/1", resp_valid, req_ready); else n_pass++;
    endtask

    task automatic test_reset_mid_store();
        logic [31:0] rd, erd;
        logic err, eerr;
        int lat;
        model(1'b1, 32'h20, 2'b10, 1'b0, 32'h0, erd, eerr);
        do_req(1'b1, 32'h20, 2'b10, 1'b0, 32'h0, rd, err, lat);
        model(1'b1, 32'h24, 2'b10, 1'b0, 32'hA5A5A5A5, erd, eerr);
        do_req(1'b1, 32'h24, 2'b10, 1'b0, 32'hA5A5A5A5, rd, err, lat);
        do_req(1'b0, 32'h24, 2'b10, 1'b0, 32'h0, rd, err, lat);
        n_total++; if (rd !== 32'hA5A5A5A5) $display("FAIL pre_reset_load got=%h want=a5a5a5a5", rd); else n_pass++;
        @(negedge clk);
        req_we = 1'b1; req_addr = 32'h20; req_size = 2'b10; req_unsigned = 1'b0; req_wdata = 32'h12345678;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n_total++; if (req_ready !== 1'b0) $display("FAIL in_wait_ready got=%b want=0", req_ready); else n_pass++;
        #2 rstd = 1'b1;
        #1;
        n_total++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) $display("FAIL async_rst_hs ready=%b valid=%b want 1/0", req_ready, resp_valid); else n_pass++;
        n_total++; if (resp_rdata !== 32'd0 || resp_err !== 1'b0) $display("FAIL async_rst_data got=%h/%b want=0/0", resp_rdata, resp_err); else n_pass++;
        @(negedge clk);
        rstd = 1'b0;
        do_req(1'b0, 32'h20, 2'b10, 1'b1, 32'h0, rd, err, lat);
        n_total++; if (rd !== 32'd0 || err !== 1'b0) $display("FAIL aborted_store got=%h/%b want=0/0", rd, err); else n_pass++;
    endtask

    // Zero-wait instance: store then load back to back with resp_ready held 1.
    task automatic test_zero_latency();
        int acyc[2], rcyc[2], na, nr;
        logic [31:0] rdv[2], wd;
        logic errv[2];
        wd = $urandom;
        na = 0; nr = 0;
        @(negedge clk);
        rstd = 1'b1;
        @(negedge clk);
        rstd = 1'b0;
        req_we0 = 1'b1; req_addr0 = 32'h0; req_size0 = 2'b10; req_unsigned0 = 1'b1; req_wdata0 = wd;
        req_valid0 = 1'b1; resp_ready0 = 1'b1;
        for (int cyc = 0; cyc < 8; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (resp_valid0 && nr < 2) begin rcyc[nr] = cyc; rdv[nr] = resp_rdata0; errv[nr] = resp_err0; nr++; end
            if (req_ready0 && req_valid0 && na < 2) begin acyc[na] = cyc; na++; end
            @(posedge clk); #1;
            if (na == 1) begin req_we0 = 1'b0; req_wdata0 = $urandom; end
            if (na >= 2) req_valid0 = 1'b0;
        end
        resp_ready0 = 1'b0;
        n_total++; if (na !== 2 || nr !== 2) $display("FAIL z_counts accepts=%0d resps=%0d want 2/2", na, nr);
        else begin
            n_pass++;
            n_total++; if (acyc[0] !== 0) $display("FAIL z_first_accept got=%0d want=0", acyc[0]); else n_pass++;
            n_total++; if (rcyc[0] !== acyc[0] + 1) $display("FAIL z_store_resp got=%0d want=%0d", rcyc[0], acyc[0] + 1); else n_pass++;
            n_total++; if (acyc[1] !== acyc[0] + 2) $display("FAIL z_second_accept got=%0d want=%0d", acyc[1], acyc[0] + 2); else n_pass++;
            n_total++; if (rcyc[1] !== acyc[1] + 1) $display("FAIL z_load_resp got=%0d want=%0d", rcyc[1], acyc[1] + 1); else n_pass++;
            n_total++; if (rdv[0] !== 32'd0 || errv[0] !== 1'b0) $display("FAIL z_store_data got=%h/%b want=0/0", rdv[0], errv[0]); else n_pass++;
            n_total++; if (rdv[1] !== wd || errv[1] !== 1'b0) $display("FAIL z_load_data got=%h/%b want=%h/0", rdv[1], errv[1], wd); else n_pass++;
        end
    endtask

    initial begin
        req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_size = 2'd0;
        req_unsigned = 1'b0; req_wdata = 32'd0; resp_ready = 1'b0;
        req_valid0 = 1'b0; req_we0 = 1'b0; req_addr0 = 32'd0; req_size0 = 2'd0;
        req_unsigned0 = 1'b0; req_wdata0 = 32'd0; resp_ready0 = 1'b0;
        test_reset();
        test_fill();
        test_directed();
        test_random();
        test_errors();
        test_hold();
        test_reset_mid_store();
        test_zero_latency();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog_timeout passed=%0d total=%0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

endmodule
